pipeline_stall_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage RV32I pipeline. Merges load-use requests

---
 rtl/cpu_ctrl_pkg.sv | 15 +
 rtl/stall_perf_cnt.sv | 16 +
 rtl/pipeline_stall_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default timing constants for the RV32I pipeline stall/flush scheduler.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    MEMWAIT = 3'd1,
    PURGE   = 3'd2,
    HALTED  = 3'd3,
    STEP    = 3'd4
  } ctrl_state_e;

  localparam int PURGE_CYC_DEF  = 2;
  localparam int MEM_TO_CYC_DEF = 255;

endpackage

// File: rtl/stall_perf_cnt.sv
// Free-running count of stalled cycles; wraps, cleared only by reset.
module stall_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)     cnt <= '0;
    else if (en) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Global stall/flush scheduler: merges load-use, dmem wait, jump purge and debug
// halt/step into one stall and one flush for the 5-stage pipeline.
module pipeline_stall_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int PURGE_CYC  = PURGE_CYC_DEF,
  parameter int MEM_TO_CYC = MEM_TO_CYC_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_use_req,
  input  logic             jmp_purge_ma,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             cpu_stop,
  input  logic             cpu_start,
  input  logic             cpu_step,
  output logic             stall,
  output logic             flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] PURGE_LD    = 3'(PURGE_CYC - 1);
  localparam logic [7:0] MEM_TO      = 8'(MEM_TO_CYC);
  localparam bit         PURGE_MULTI = (PURGE_CYC > 1);

  ctrl_state_e state_q, state_d;
  logic [2:0]  purge_cnt, purge_d;
  logic [7:0]  wait_cnt, wait_d;
  logic        ret_halt, ret_d;
  logic        err_set;
  ctrl_state_e exit_st;

  // MEMWAIT/PURGE entered from a single step must land back in HALTED.
  assign exit_st = ret_halt ? HALTED : RUN;

  always_comb begin
    state_d = state_q;
    purge_d = purge_cnt;
    wait_d  = wait_cnt;
    ret_d   = ret_halt;
    err_set = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    halted  = 1'b0;
    case (state_q)
      RUN, STEP: begin
        halted = (state_q == STEP);
        if (jmp_purge_ma) begin
          flush = 1'b1;
          if (PURGE_MULTI) begin
            state_d = PURGE;
            purge_d = PURGE_LD;
            ret_d   = (state_q == STEP);
          end else begin
            state_d = (state_q == STEP) ? HALTED : RUN;
          end
        end else if (dmem_req && !dmem_ack) begin
          stall   = 1'b1;
          state_d = MEMWAIT;
          wait_d  = 8'd1;
          ret_d   = (state_q == STEP);
        end else if (ld_use_req) begin
          // A load-use bubble during a step keeps the step pending until it issues.
          stall = 1'b1;
        end else if (state_q == STEP || cpu_stop) begin
          state_d = HALTED;
        end
      end
      MEMWAIT: begin
        stall = 1'b1;
        if (dmem_ack) begin
          state_d = exit_st;
          ret_d   = 1'b0;
        end else if (wait_cnt >= MEM_TO) begin
          err_set = 1'b1;
          state_d = exit_st;
          ret_d   = 1'b0;
        end else begin
          wait_d = wait_cnt + 8'd1;
        end
      end
      PURGE: begin
        flush = 1'b1;
        if (jmp_purge_ma) begin
          purge_d = PURGE_LD;
        end else if (purge_cnt <= 3'd1) begin
          purge_d = 3'd0;
          state_d = exit_st;
          ret_d   = 1'b0;
        end else begin
          purge_d = purge_cnt - 3'd1;
        end
      end
      HALTED: begin
        stall  = 1'b1;
        halted = 1'b1;
        if (cpu_start)     state_d = RUN;
        else if (cpu_step) state_d = STEP;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      purge_cnt <= '0;
      wait_cnt  <= '0;
      ret_halt  <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      purge_cnt <= purge_d;
      wait_cnt  <= wait_d;
      ret_halt  <= ret_d;
      mem_err   <= mem_err | err_set;
    end
  end

  stall_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk (clk),
    .rst (rst),
    .en  (stall),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_stall_ctrl;

  localparam int PURGE_CYC  = 2;
  localparam int MEM_TO_CYC = 4;
  localparam int CNT_W      = 32;

  logic clk = 1'b0;
  logic rst = 1'b0, ld_use_req = 1'b0, jmp_purge_ma = 1'b0, dmem_req = 1'b0, dmem_ack = 1'b0;
  logic cpu_stop = 1'b0, cpu_start = 1'b0, cpu_step = 1'b0;
  logic stall, flush, halted, mem_err;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.PURGE_CYC(PURGE_CYC), .MEM_TO_CYC(MEM_TO_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ld_use_req(ld_use_req), .jmp_purge_ma(jmp_purge_ma),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .cpu_stop(cpu_stop), .cpu_start(cpu_start),
    .cpu_step(cpu_step), .stall(stall), .flush(flush), .halted(halted), .mem_err(mem_err),
    .stall_cnt(stall_cnt)
  );

  int n_pass = 0, n_total = 0;

  // Model: debug mode 0=running 1=halted 2=step cycle; flush cycles owed; memory wait
  // progress; whether the current excursion returns to halted.
  int m_dbg = 0, m_flush_left = 0, m_mw_n = 0;
  bit m_mw = 0, m_ret = 0, m_err = 0;
  logic [CNT_W-1:0] m_cnt = '0;
  int n_dbg = 0, n_flush_left = 0, n_mw_n = 0;
  bit n_mw = 0, n_ret = 0, n_err = 0;
  logic [CNT_W-1:0] n_cnt = '0;
  bit e_stall, e_flush, e_halted;

  task automatic model_eval();
    e_stall = 0; e_flush = 0; e_halted = 0;
    n_dbg = m_dbg; n_flush_left = m_flush_left; n_mw = m_mw; n_mw_n = m_mw_n;
    n_ret = m_ret; n_err = m_err;
    if (rst) begin
      n_dbg = 0; n_flush_left = 0; n_mw = 0; n_mw_n = 0; n_ret = 0; n_err = 0;
    end else if (m_mw) begin
      e_stall = 1;
      n_mw_n = m_mw_n + 1;
      if (dmem_ack || n_mw_n == MEM_TO_CYC) begin
        if (!dmem_ack) n_err = 1;
        n_mw = 0; n_dbg = m_ret ? 1 : 0; n_ret = 0;
      end
    end else if (m_flush_left > 0) begin
      e_flush = 1;
      n_flush_left = jmp_purge_ma ? PURGE_CYC - 1 : m_flush_left - 1;
      if (n_flush_left == 0) begin n_dbg = m_ret ? 1 : 0; n_ret = 0; end
    end else if (m_dbg == 1) begin
      e_stall = 1; e_halted = 1;
      if (cpu_start) n_dbg = 0;
      else if (cpu_step) n_dbg = 2;
    end else begin
      e_halted = (m_dbg == 2);
      if (jmp_purge_ma) begin
        e_flush = 1;
        n_flush_left = PURGE_CYC - 1;
        n_ret = (m_dbg == 2) && (n_flush_left > 0);
        n_dbg = (m_dbg == 2 && n_flush_left == 0) ? 1 : 0;
      end else if (dmem_req && !dmem_ack) begin
        e_stall = 1; n_mw = 1; n_mw_n = 0; n_ret = (m_dbg == 2); n_dbg = 0;
      end else if (ld_use_req) begin
        e_stall = 1;
      end else if (m_dbg == 2 || cpu_stop) begin
        n_dbg = 1;
      end
    end
    n_cnt = rst ? '0 : m_cnt + CNT_W'(e_stall);
  endtask

  // Advance one cycle: commit model, apply inputs, settle to the falling edge, predict.
  task automatic drive(input bit r, lu, jp, rq, ak, sp, st, sg);
    @(posedge clk); #1;
    m_dbg = n_dbg; m_flush_left = n_flush_left; m_mw = n_mw; m_mw_n = n_mw_n;
    m_ret = n_ret; m_err = n_err; m_cnt = n_cnt;
    rst = r; ld_use_req = lu; jmp_purge_ma = jp; dmem_req = rq; dmem_ack = ak;
    cpu_stop = sp; cpu_start = st; cpu_step = sg;
    @(negedge clk);
    model_eval();
  endtask

  task automatic test_reset();
    drive(1,0,0,0,0,0,0,0);
    drive(1,0,0,0,0,0,0,0);
    drive(0,0,0,0,0,0,0,0);
    n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
    n_total++; if (flush !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush); else n_pass++;
    n_total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
    n_total++; if (mem_err !== 1'b0) $display("FAIL reset_mem_err: got %b want 0", mem_err); else n_pass++;
    n_total++; if (stall_cnt !== '0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
  endtask

  task automatic test_ld_use();
    logic [CNT_W-1:0] base;
    base = m_cnt;
    drive(0,1,0,0,0,0,0,0);
    n_total++; if (stall !== 1'b1) $display("FAIL ld_use_stall: got %b want 1", stall); else n_pass++;
    drive(0,0,0,0,0,0,0,0);
    n_total++; if (stall !== 1'b0) $display("FAIL ld_use_release: got %b want 0", stall); else n_pass++;
    n_total++; if (stall_cnt !== base + 1) $display("FAIL ld_use_cnt: got %0d want %0d", stall_cnt, base + 1); else n_pass++;
  endtask

  task automatic test_mem_ack();
    logic [CNT_W-1:0] base;
    base = m_cnt;
    drive(0,0,0,1,0,0,0,0);
    n_total++; if (stall !== 1'b1) $display("FAIL mem_req_stall: got %b want 1", stall); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      drive(0,0,0,0,0,0,0,0);
      n_total++; if (stall !== 1'b1) $display("FAIL mem_wait_stall: cyc %0d got %b want 1", i, stall); else n_pass++;
    end
    drive(0,0,0,0,1,0,0,0);
    n_total++; if (stall !== 1'b1) $display("FAIL mem_ack_stall: got %b want 1", stall); else n_pass++;
    drive(0,0,0,0,0,0,0,0);
    n_total++; if (stall !== 1'b0) $display("FAIL mem_after_ack: got %b want 0", stall); else n_pass++;
    n_total++; if (stall_cnt !== base + 4) $display("FAIL mem_ack_cnt: got %0d want %0d", stall_cnt, base + 4); else n_pass++;
  endtask

  task automatic test_mem_timeout();
    logic [CNT_W-1:0] base;
    base = m_cnt;
    drive(0,0,0,1,0,0,0,0);
    for (int i = 0; i < MEM_TO_CYC; i++) begin
      drive(0,0,0,0,0,0,0,0);
      n_total++; if (stall !== 1'b1 || mem_err !== 1'b0)
        $display("FAIL mem_to_wait: cyc %0d got stall=%b err=%b want 1/0", i, stall, mem_err); else n_pass++;
    end
    drive(0,0,0,0,0,0,0,0);
    n_total++; if (stall !== 1'b0) $display("FAIL mem_to_run: got %b want 0", stall); else n_pass++;
    n_total++; if (stall_cnt !== base + MEM_TO_CYC + 1)
      $display("FAIL mem_to_cnt: got %0d want %0d", stall_cnt, base + MEM_TO_CYC + 1); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(0,0,0,0,0,0,0,0);
      n_total++; if (mem_err !== 1'b1) $display("FAIL mem_err_sticky: cyc %0d got %b want 1", i, mem_err); else n_pass++;
    end
  endtask

  task automatic test_jump_lduse();
    drive(0,1,1,0,0,0,0,0);
    n_total++; if (flush !== 1'b1 || stall !== 1'b0)
      $display("FAIL jump_c0: got flush=%b stall=%b want 1/0", flush, stall); else n_pass++;
    drive(0,0,0,0,0,0,0,0);
    n_total++; if (flush !== 1'b1 || stall !== 1'b0)
      $display("FAIL jump_c1: got flush=%b stall=%b want 1/0", flush, stall); else n_pass++;
    drive(0,0,0,0,0,0,0,0);
    n_total++; if (flush !== 1'b0 || stall !== 1'b0)
      $display("FAIL jump_done: got flush=%b stall=%b want 0/0", flush, stall); else n_pass++;
  endtask

  task automatic test_debug();
    drive(0,0,0,0,0,1,0,0);
    n_total++; if (stall !== 1'b0 || halted !== 1'b0)
      $display("FAIL dbg_stop_cyc: got stall=%b halted=%b want 0/0", stall, halted); else n_pass++;
    drive(0,0,0,0,0,1,0,0);
    n_total++; if (stall !== 1'b1 || halted !== 1'b1)
      $display("FAIL dbg_halted: got stall=%b halted=%b want 1/1", stall, halted); else n_pass++;
    drive(0,0,0,0,0,0,0,1);
    n_total++; if (stall !== 1'b1 || halted !== 1'b1)
      $display("FAIL dbg_step_req: got stall=%b halted=%b want 1/1", stall, halted); else n_pass++;
    drive(0,0,0,0,0,0,0,0);
    n_total++; if (stall !== 1'b0 || halted !== 1'b1)
      $display("FAIL dbg_step_cyc: got stall=%b halted=%b want 0/1", stall, halted); else n_pass++;
    drive(0,0,0,0,0,0,0,0);
    n_total++; if (stall !== 1'b1 || halted !== 1'b1)
      $display("FAIL dbg_rehalt: got stall=%b halted=%b want 1/1", stall, halted); else n_pass++;
    drive(0,0,0,0,0,0,1,0);
    drive(0,0,0,0,0,0,0,0);
    n_total++; if (stall !== 1'b0 || halted !== 1'b0)
      $display("FAIL dbg_resume: got stall=%b halted=%b want 0/0", stall, halted); else n_pass++;
  endtask

  task automatic test_rst_memwait();
    drive(0,0,0,1,0,0,0,0);
    drive(0,0,0,0,0,0,0,0);
    n_total++; if (stall !== 1'b1) $display("FAIL rst_mw_pre: got %b want 1", stall); else n_pass++;
    drive(1,0,0,0,0,0,0,0);
    drive(0,0,0,0,0,0,0,0);
    n_total++; if (stall !== 1'b0 || flush !== 1'b0 || halted !== 1'b0)
      $display("FAIL rst_mw_outs: got stall=%b flush=%b halted=%b want 0/0/0", stall, flush, halted); else n_pass++;
    n_total++; if (mem_err !== 1'b0) $display("FAIL rst_mw_err: got %b want 0", mem_err); else n_pass++;
    n_total++; if (stall_cnt !== '0) $display("FAIL rst_mw_cnt: got %0d want 0", stall_cnt); else n_pass++;
  endtask

  task automatic test_random();
    bit stop_lvl;
    bit r;
    stop_lvl = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 6) stop_lvl = ~stop_lvl;
      r = ($urandom_range(0, 199) == 0);
      drive(r, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 30, stop_lvl, $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 15);
      if (!r) begin
        n_total++; if (stall !== e_stall) $display("FAIL rnd_stall: cyc %0d got %b want %b", i, stall, e_stall); else n_pass++;
        n_total++; if (flush !== e_flush) $display("FAIL rnd_flush: cyc %0d got %b want %b", i, flush, e_flush); else n_pass++;
        n_total++; if (halted !== e_halted) $display("FAIL rnd_halted: cyc %0d got %b want %b", i, halted, e_halted); else n_pass++;
      end
      n_total++; if (mem_err !== m_err) $display("FAIL rnd_mem_err: cyc %0d got %b want %b", i, mem_err, m_err); else n_pass++;
      n_total++; if (stall_cnt !== m_cnt) $display("FAIL rnd_stall_cnt: cyc %0d got %0d want %0d", i, stall_cnt, m_cnt); else n_pass++;
      n_total++; if (stall === 1'b1 && flush === 1'b1) $display("FAIL rnd_exclusive: cyc %0d got both 1 want not both", i); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_ld_use();
    test_mem_ack();
    test_mem_timeout();
    test_jump_lduse();
    test_debug();
    test_rst_memwait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
